// File: rtl/craps_pkg.sv
// Shared types for the craps dice path: die values, roll FSM states and die helpers.
package craps_pkg;

  localparam int unsigned DIE_W = 4;
  localparam int unsigned SUM_W = 4;

  typedef logic [DIE_W-1:0] die_t;

  localparam die_t DIE_BLANK = 4'd0;
  localparam die_t DIE_MIN   = 4'd1;
  localparam die_t DIE_MAX   = 4'd6;

  typedef enum logic [1:0] {
    IDLE,
    ROLL,
    SETTLE,
    DONE
  } roll_state_t;

  // Advance one die face, wrapping 6 -> 1.
  function automatic die_t die_next(input die_t d);
    return (d >= DIE_MAX) ? DIE_MIN : die_t'(d + die_t'(1));
  endfunction

  function automatic logic die_valid(input die_t d);
    return (d >= DIE_MIN) && (d <= DIE_MAX);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running tick generator: tick is high for one cycle every TICK_DIV cycles.
// tick_pre_c flags the cycle just before a tick so consumers can register tick-aligned outputs.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  output logic tick,
  output logic tick_pre_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] count;

  assign tick_pre_c = (count == CNT_W'(TICK_DIV - 2));

  // tick is registered: it rises together with count reaching TICK_DIV-1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      count <= tick ? '0 : CNT_W'(count + CNT_W'(1));
      tick  <= tick_pre_c;
    end
  end

endmodule

// File: rtl/dice_roller.sv
// Dice roller: spins two dice while the roll button is held, settles them on display ticks,
// then reports the frozen pair and its sum. Define LOADED_DICE_EN to allow forcing the result.
module dice_roller
  import craps_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 50000,
  parameter int unsigned MIN_ROLL_TICKS = 4,
  parameter int unsigned SETTLE_TICKS   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             roll_btn,
`ifdef LOADED_DICE_EN
  input  logic             force_en,
  input  die_t             force_d1,
  input  die_t             force_d2,
`endif
  output die_t             dice1,
  output die_t             dice2,
  output logic             disp_en,
  output logic [SUM_W-1:0] sum,
  output logic             roll_done,
  output logic             busy
);

  localparam int unsigned RCNT_W = (MIN_ROLL_TICKS > 0) ? $clog2(MIN_ROLL_TICKS + 1) : 1;
  localparam int unsigned SCNT_W = $clog2(SETTLE_TICKS + 1);

  logic sync_meta;
  logic btn_s;
  logic btn_hist;
  logic press_c;
  logic tick;
  logic tick_pre_c;

  roll_state_t      state, state_n;
  logic [RCNT_W-1:0] roll_cnt, roll_cnt_n;
  logic [SCNT_W-1:0] settle_cnt, settle_cnt_n;
  die_t             dice1_n, dice2_n;
  die_t             step1_c, step2_c;
  logic [SUM_W-1:0] sum_n;
  logic             disp_en_n, roll_done_n, busy_n;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clock     (clock),
    .reset     (reset),
    .tick      (tick),
    .tick_pre_c(tick_pre_c)
  );

  // Synchronizer and edge history reset high so a button held through reset is not a press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b1;
      btn_s     <= 1'b1;
      btn_hist  <= 1'b1;
    end else begin
      sync_meta <= roll_btn;
      btn_s     <= sync_meta;
      btn_hist  <= btn_s;
    end
  end

  assign press_c = btn_s & ~btn_hist;

  // Die 2 carries only when die 1 wraps, so the pair walks all 36 outcomes.
  assign step1_c = die_next(dice1);
  assign step2_c = (dice1 == DIE_MAX) ? die_next(dice2) : dice2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      roll_cnt   <= '0;
      settle_cnt <= '0;
      dice1      <= DIE_BLANK;
      dice2      <= DIE_BLANK;
      sum        <= '0;
      disp_en    <= 1'b0;
      roll_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      roll_cnt   <= roll_cnt_n;
      settle_cnt <= settle_cnt_n;
      dice1      <= dice1_n;
      dice2      <= dice2_n;
      sum        <= sum_n;
      disp_en    <= disp_en_n;
      roll_done  <= roll_done_n;
      busy       <= busy_n;
    end
  end

  always_comb begin
    state_n      = state;
    roll_cnt_n   = roll_cnt;
    settle_cnt_n = settle_cnt;
    dice1_n      = dice1;
    dice2_n      = dice2;
    sum_n        = sum;

    case (state)
      IDLE: begin
        if (press_c) begin
          state_n    = ROLL;
          roll_cnt_n = '0;
          dice1_n    = (dice1 == DIE_BLANK) ? DIE_MIN : dice1;
          dice2_n    = (dice2 == DIE_BLANK) ? DIE_MIN : dice2;
        end
      end
      ROLL: begin
        dice1_n = step1_c;
        dice2_n = step2_c;
        if (tick && (roll_cnt < RCNT_W'(MIN_ROLL_TICKS))) begin
          roll_cnt_n = RCNT_W'(roll_cnt + RCNT_W'(1));
        end
        if (!btn_s && (roll_cnt >= RCNT_W'(MIN_ROLL_TICKS))) begin
          state_n      = SETTLE;
          settle_cnt_n = '0;
        end
      end
      SETTLE: begin
        if (tick) begin
          dice1_n      = step1_c;
          dice2_n      = step2_c;
          settle_cnt_n = SCNT_W'(settle_cnt + SCNT_W'(1));
          if (settle_cnt == SCNT_W'(SETTLE_TICKS - 1)) begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
`ifdef LOADED_DICE_EN
        if (force_en) begin
          if (die_valid(force_d1)) dice1_n = force_d1;
          if (die_valid(force_d2)) dice2_n = force_d2;
        end
`endif
        sum_n = SUM_W'(dice1_n) + SUM_W'(dice2_n);
      end
      default: state_n = IDLE;
    endcase

    // Strobes are registered from the next state so they line up with the state they describe.
    busy_n      = (state_n != IDLE);
    roll_done_n = (state_n == DONE);
    disp_en_n   = (state_n == DONE) ||
                  (((state_n == ROLL) || (state_n == SETTLE)) && tick_pre_c);
  end

endmodule

// File: tb/tb_dice_roller.sv
// Scoreboard bench for dice_roller: each roll's timing window and outcome is predicted up front
// from button timing and pushed to a queue; a negedge monitor compares every cycle.
module tb_dice_roller;

  localparam int TD   = 4;
  localparam int MINT = 2;
  localparam int ST   = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       roll_btn = 1'b0;
  logic [3:0] dice1, dice2, sum;
  logic       disp_en, roll_done, busy;
`ifdef LOADED_DICE_EN
  logic       force_en = 1'b0;
  logic [3:0] force_d1 = 4'd0;
  logic [3:0] force_d2 = 4'd0;
`endif

  always #5 clock = ~clock;

  dice_roller #(
    .TICK_DIV      (TD),
    .MIN_ROLL_TICKS(MINT),
    .SETTLE_TICKS  (ST)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .roll_btn (roll_btn),
`ifdef LOADED_DICE_EN
    .force_en (force_en),
    .force_d1 (force_d1),
    .force_d2 (force_d2),
`endif
    .dice1    (dice1),
    .dice2    (dice2),
    .disp_en  (disp_en),
    .sum      (sum),
    .roll_done(roll_done),
    .busy     (busy)
  );

  typedef struct {
    int r;   // first busy cycle
    int e;   // last ROLL cycle
    int d;   // DONE cycle
    int n1;  // natural dice in DONE
    int n2;
    int f1;  // dice after DONE (possibly forced)
    int f2;
    int s;
  } win_t;

  win_t wq[$];
  win_t last;
  bit   have_last = 1'b0;
  int   cyc;
  int   compared = 0;
  int   mismatched = 0;
  int   cur_idx = 0;
  bit   blank = 1'b1;

  // Cycle index since reset release; the DUT tick counter has the same phase.
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int ticks_in(input int a, input int b);
    int k = 0;
    for (int n = a; n <= b; n++) if (n % TD == TD - 1) k++;
    return k;
  endfunction

  // Predict a roll whose button rises in cycle p and falls in cycle p+hold.
  task automatic plan_roll(input int p, input int hold, input bit fen, input int fd1, input int fd2);
    win_t w;
    int   n, k, steps, idx;
    w.r = p + 3;
    w.e = p + hold + 2;
    while (ticks_in(w.r, w.e - 1) < MINT) w.e++;
    n = w.e;
    k = 0;
    while (k < ST) begin
      n++;
      if (n % TD == TD - 1) k++;
    end
    w.d   = n + 1;
    steps = (w.e - w.r + 1) + ST;
    idx   = blank ? 0 : cur_idx;
    idx   = (idx + steps) % 36;
    w.n1  = idx % 6 + 1;
    w.n2  = idx / 6 + 1;
    w.f1  = w.n1;
    w.f2  = w.n2;
    if (fen) begin
      if (fd1 >= 1 && fd1 <= 6) w.f1 = fd1;
      if (fd2 >= 1 && fd2 <= 6) w.f2 = fd2;
    end
    w.s     = w.f1 + w.f2;
    cur_idx = (w.f2 - 1) * 6 + (w.f1 - 1);
    blank   = 1'b0;
    wq.push_back(w);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic run_roll(input int hold, input bit repress, input bit fen, input int fd1, input int fd2);
    win_t w;
    @(negedge clock);
`ifdef LOADED_DICE_EN
    force_en = fen;
    force_d1 = 4'(fd1);
    force_d2 = 4'(fd2);
`endif
    plan_roll(cyc, hold, fen, fd1, fd2);
    w = wq[wq.size() - 1];
    roll_btn = 1'b1;
    repeat (hold) @(negedge clock);
    roll_btn = 1'b0;
    if (repress) begin
      wait_until(w.e + 2);
      roll_btn = 1'b1;
      @(negedge clock);
      roll_btn = 1'b0;
      wait_until(w.d - 2);
      roll_btn = 1'b1;
      @(negedge clock);
      roll_btn = 1'b0;
    end
    wait_until(w.d + 2);
`ifdef LOADED_DICE_EN
    force_en = 1'b0;
`endif
    repeat ($urandom_range(2, 6)) @(negedge clock);
  endtask

  // Monitor: busy/done/disp_en windows, frozen dice and held sum every cycle.
  always @(negedge clock) begin
    bit exp_busy, exp_done, exp_disp;
    int exp_sum;
    if (!reset) begin
      while (wq.size() > 0 && wq[0].d < cyc) begin
        last = wq.pop_front();
        have_last = 1'b1;
      end
      exp_busy = (wq.size() > 0) && (cyc >= wq[0].r);
      exp_done = exp_busy && (cyc == wq[0].d);
      exp_disp = exp_busy && (exp_done || (cyc % TD == TD - 1));
      exp_sum  = have_last ? last.s : 0;
      check("busy", int'(busy), int'(exp_busy));
      check("roll_done", int'(roll_done), int'(exp_done));
      check("disp_en", int'(disp_en), int'(exp_disp));
      check("sum", int'(sum), exp_sum);
      if (exp_done) begin
        check("done_dice1", int'(dice1), wq[0].n1);
        check("done_dice2", int'(dice2), wq[0].n2);
      end
      if (!exp_busy) begin
        check("idle_dice1", int'(dice1), have_last ? last.f1 : 0);
        check("idle_dice2", int'(dice2), have_last ? last.f2 : 0);
      end
    end
  end

  task automatic check_reset_values();
    check("rst_dice1", int'(dice1), 0);
    check("rst_dice2", int'(dice2), 0);
    check("rst_sum", int'(sum), 0);
    check("rst_disp_en", int'(disp_en), 0);
    check("rst_roll_done", int'(roll_done), 0);
    check("rst_busy", int'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "watchdog");
  end

  initial begin
    // Button held high across reset release must not start a roll.
    reset    = 1'b1;
    roll_btn = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_values();
    reset = 1'b0;
    repeat (100) @(negedge clock);
    roll_btn = 1'b0;
    repeat (5) @(negedge clock);

    run_roll(40, 1'b0, 1'b0, 0, 0);
    run_roll(2, 1'b0, 1'b0, 0, 0);
    run_roll(1, 1'b0, 1'b0, 0, 0);
    run_roll(6, 1'b1, 1'b0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      run_roll(int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)), 1'b0, 0, 0);
    end

    // Reset in the middle of ROLL clears everything and emits no roll_done.
    @(negedge clock);
    plan_roll(cyc, 30, 1'b0, 0, 0);
    roll_btn = 1'b1;
    repeat (12) @(negedge clock);
    reset    = 1'b1;
    roll_btn = 1'b0;
    #1;
    check_reset_values();
    wq.delete();
    have_last = 1'b0;
    blank     = 1'b1;
    cur_idx   = 0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    run_roll(8, 1'b1, 1'b0, 0, 0);
    run_roll(3, 1'b0, 1'b0, 0, 0);

`ifdef LOADED_DICE_EN
    run_roll(10, 1'b0, 1'b1, 3, 4);
    run_roll(12, 1'b0, 1'b1, 9, 2);
    run_roll(5, 1'b0, 1'b1, 6, 5);
`endif

    repeat (10) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
